// File: rtl/keypad_gear_input_pkg.sv
// Shared constants for the keypad / gear selector path.
// Gear codes match the 4-bit characters the display unit consumes.
package keypad_gear_input_pkg;

  localparam logic [3:0] GEAR_P    = 4'd3;
  localparam logic [3:0] GEAR_R    = 4'd6;
  localparam logic [3:0] GEAR_N    = 4'd9;
  localparam logic [3:0] GEAR_D    = 4'd12;
  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_MULTI = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } deb_state_e;

  function automatic logic is_gear(input logic [3:0] k);
    return (k == GEAR_P) || (k == GEAR_R) || (k == GEAR_N) || (k == GEAR_D);
  endfunction

endpackage

// File: rtl/keypad_matrix_scan.sv
// Keypad matrix scanner: 2-flop row synchronizer, column counter and
// per-frame key code.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick_scan       scan strobe; samples current column then advances
//   key_row         raw active-low rows (asynchronous)
//   key_col         active-low column drive, one bit low
//   frame_done      high in the cycle of the tick that samples the last column
//   frame_code      valid with frame_done: 0 none, 1..12 single key, 15 multiple
module keypad_matrix_scan
  import keypad_gear_input_pkg::*;
#(
  parameter int NUM_COLS = 3,
  parameter int NUM_ROWS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_scan,
  input  logic [NUM_ROWS-1:0] key_row,
  output logic [NUM_COLS-1:0] key_col,
  output logic                frame_done,
  output logic [3:0]          frame_code
);

  localparam logic [NUM_COLS-1:0] COL_ONE  = NUM_COLS'(1);
  localparam logic [1:0]          COL_LAST = 2'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] sync1_q, sync2_q;
  logic [1:0]          col_idx_q, col_idx_d;
  // Partial frame: saturating key count (0,1,2+) and code of the first key seen
  logic [1:0]          acc_cnt_q, acc_cnt_d;
  logic [3:0]          acc_code_q, acc_code_d;
  logic [1:0]          frm_cnt;
  logic [3:0]          frm_code;

  always_comb begin
    col_idx_d  = col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    // Column 0 starts a fresh frame, so stale accumulator contents never leak
    frm_cnt  = (col_idx_q == 2'd0) ? 2'd0 : acc_cnt_q;
    frm_code = (col_idx_q == 2'd0) ? KEY_NONE : acc_code_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!sync2_q[r]) begin
        if (frm_cnt == 2'd0) frm_code = 4'(r * NUM_COLS + int'(col_idx_q) + 1);
        if (frm_cnt != 2'd2) frm_cnt = frm_cnt + 2'd1;
      end
    end
    if (tick_scan) begin
      acc_cnt_d  = frm_cnt;
      acc_code_d = frm_code;
      col_idx_d  = (col_idx_q == COL_LAST) ? 2'd0 : col_idx_q + 2'd1;
    end
    frame_done = tick_scan && (col_idx_q == COL_LAST);
    case (frm_cnt)
      2'd0:    frame_code = KEY_NONE;
      2'd1:    frame_code = frm_code;
      default: frame_code = KEY_MULTI;
    endcase
    key_col = ~(COL_ONE << col_idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      col_idx_q  <= 2'd0;
      acc_cnt_q  <= 2'd0;
      acc_code_q <= KEY_NONE;
    end else begin
      sync1_q    <= key_row;
      sync2_q    <= sync1_q;
      col_idx_q  <= col_idx_d;
      acc_cnt_q  <= acc_cnt_d;
      acc_code_q <= acc_code_d;
    end
  end

endmodule

// File: rtl/keypad_gear_input.sv
// Keypad input path: scans and debounces the 3x4 keypad, emits one event per
// press and owns the gear selector with its speed interlock.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   tick_scan     scan strobe shared with the display scan
//   key_row       raw active-low rows;  key_col  active-low column drive
//   speed         vehicle speed for the gear interlock
//   key_code      last accepted key (0 = none since reset)
//   key_valid     one-cycle pulse per accepted press
//   key_pressed   debounced key held
//   gear_char     current gear (3 P, 6 R, 9 N, 12 D)
//   gear_reject   one-cycle pulse when the interlock refuses a gear key
module keypad_gear_input
  import keypad_gear_input_pkg::*;
#(
  parameter int NUM_COLS        = 3,
  parameter int NUM_ROWS        = 4,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_scan,
  input  logic [NUM_ROWS-1:0] key_row,
  input  logic [7:0]          speed,
  output logic [NUM_COLS-1:0] key_col,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_pressed,
  output logic [3:0]          gear_char,
  output logic                gear_reject
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);

  logic       frame_done;
  logic [3:0] frame_code;

  keypad_matrix_scan #(.NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .tick_scan  (tick_scan),
    .key_row    (key_row),
    .key_col    (key_col),
    .frame_done (frame_done),
    .frame_code (frame_code)
  );

  deb_state_e state_q, state_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_pressed_q, key_pressed_d;
  logic [3:0] gear_q, gear_d;
  logic       gear_reject_q, gear_reject_d;
  logic       gear_ok;

  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_pressed_d = key_pressed_q;
    gear_d        = gear_q;
    gear_reject_d = 1'b0;

    if (frame_done) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_code != KEY_NONE && frame_code != KEY_MULTI) begin
            state_d = ST_PRESS_CHK;
            cand_d  = frame_code;
            cnt_d   = 4'd1;
          end
        end
        ST_PRESS_CHK: begin
          if (frame_code == cand_q) begin
            if (cnt_q + 4'd1 == DEB_N) begin
              state_d       = ST_HELD;
              cnt_d         = 4'd0;
              key_code_d    = cand_q;
              key_valid_d   = 1'b1;
              key_pressed_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_HELD: begin
          // Any non-empty frame (including a second key) just keeps the hold
          if (frame_code == KEY_NONE) begin
            state_d = ST_REL_CHK;
            cnt_d   = 4'd1;
          end
        end
        default: begin // ST_REL_CHK
          if (frame_code == KEY_NONE) begin
            if (cnt_q + 4'd1 == DEB_N) begin
              state_d       = ST_IDLE;
              cnt_d         = 4'd0;
              key_pressed_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end

    // Interlock: N always; re-selecting the current gear is a silent no-op;
    // D from N or D while moving; anything else needs a standstill.
    gear_ok = (key_code_q == GEAR_N) || (key_code_q == gear_q) || (speed == 8'd0) ||
              ((key_code_q == GEAR_D) && (gear_q == GEAR_N || gear_q == GEAR_D));
    if (key_valid_q && is_gear(key_code_q)) begin
      if (gear_ok) gear_d        = key_code_q;
      else         gear_reject_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cand_q        <= KEY_NONE;
      cnt_q         <= 4'd0;
      key_code_q    <= KEY_NONE;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      gear_q        <= GEAR_P;
      gear_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_pressed_q <= key_pressed_d;
      gear_q        <= gear_d;
      gear_reject_q <= gear_reject_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_pressed = key_pressed_q;
  assign gear_char   = gear_q;
  assign gear_reject = gear_reject_q;

endmodule
